// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter: requester IDs,
// per-requester state encodings, ALU operation codes and issue-stage control fields.
package alu_share_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_AUX  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } req_state_e;

  // Operation set of the shared ALU; ALU_XXX is what the decoder emits for unknown opcodes.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_XXX    = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct;
    logic       add_rshift_type;
    logic       owner;
  } iss_ctrl_t;

endpackage

// File: rtl/alu_share_rr.sv
// Two-way grant logic for the shared ALU. Default build is round-robin with a
// pointer that flips on contested grants; ALU_ARB_FIXED_PRI_EN makes requester 0 always win.
module alu_share_rr
  import alu_share_arb_pkg::*;
(
`ifndef ALU_ARB_FIXED_PRI_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRI_EN

  always_comb begin
    grant = 2'b00;
    if (eligible[REQ_PIPE]) begin
      grant[REQ_PIPE] = 1'b1;
    end else if (eligible[REQ_AUX]) begin
      grant[REQ_AUX] = 1'b1;
    end
  end

`else

  logic ptr;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant[ptr] = 1'b1;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: flops use non-blocking assignment so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= REQ_PIPE;
    end else if (&eligible) begin
      ptr <= ~ptr;
    end
  end

`endif

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALUdec+ALU between the integer pipeline (0) and an auxiliary unit (1)
// through a single issue stage. Optional macro: ALU_ARB_FIXED_PRI_EN (fixed priority to requester 0).
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*7-1:0]       req_opcode,
  input  logic [NUM_REQ*3-1:0]       req_funct,
  input  logic [NUM_REQ-1:0]         req_add_rshift_type,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [6:0]                 alu_opcode,
  output logic [2:0]                 alu_funct,
  output logic                       alu_add_rshift_type,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  input  logic [WIDTH-1:0]           alu_result,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [NUM_REQ*WIDTH-1:0]   rsp_data,
  output logic [NUM_REQ*TAG_W-1:0]   rsp_tag
);

  req_state_e [NUM_REQ-1:0] state_q;
  req_state_e [NUM_REQ-1:0] state_d;

  logic               ready_en_q;
  logic [NUM_REQ-1:0] idle;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               win_id;

  iss_ctrl_t          ctrl_in [NUM_REQ];
  logic [WIDTH-1:0]   a_in    [NUM_REQ];
  logic [WIDTH-1:0]   b_in    [NUM_REQ];
  logic [TAG_W-1:0]   tag_in  [NUM_REQ];

  logic               iss_vld_q;
  iss_ctrl_t          iss_ctrl_q;
  logic [WIDTH-1:0]   iss_a_q;
  logic [WIDTH-1:0]   iss_b_q;
  logic [TAG_W-1:0]   iss_tag_q;

  // Ready is held low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign ctrl_in[i] = '{opcode:          req_opcode[i*7 +: 7],
                          funct:           req_funct[i*3 +: 3],
                          add_rshift_type: req_add_rshift_type[i],
                          owner:           1'(i)};
    assign a_in[i]    = req_a[i*WIDTH +: WIDTH];
    assign b_in[i]    = req_b[i*WIDTH +: WIDTH];
    assign tag_in[i]  = req_tag[i*TAG_W +: TAG_W];

    assign idle[i]      = (state_q[i] == ST_IDLE);
    assign eligible[i]  = ready_en_q & idle[i] & req_valid[i];
    // A contested loser sees ready low, so valid&ready always means consumed.
    assign req_ready[i] = ready_en_q & idle[i] & (~req_valid[i] | grant[i]);
    assign rsp_valid[i] = (state_q[i] == ST_RESP);
  end

`ifdef ALU_ARB_FIXED_PRI_EN
  alu_share_rr u_arb (
    .eligible (eligible),
    .grant    (grant)
  );
`else
  alu_share_rr u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .grant    (grant)
  );
`endif

  assign win_id = grant[REQ_AUX];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE:  if (grant[i]) state_d[i] = ST_ISSUE;
        ST_ISSUE: state_d[i] = ST_RESP;
        ST_RESP:  if (rsp_ready[i]) state_d[i] = ST_IDLE;
        default:  state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= ST_IDLE;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: datapath registers are reset as well so alu_* and rsp_* read zero out of reset, never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld_q  <= 1'b0;
      iss_ctrl_q <= '0;
      iss_a_q    <= '0;
      iss_b_q    <= '0;
      iss_tag_q  <= '0;
    end else begin
      iss_vld_q <= |grant;
      if (|grant) begin
        iss_ctrl_q <= ctrl_in[win_id];
        iss_a_q    <= a_in[win_id];
        iss_b_q    <= b_in[win_id];
        iss_tag_q  <= tag_in[win_id];
      end
    end
  end

  assign alu_opcode          = iss_ctrl_q.opcode;
  assign alu_funct           = iss_ctrl_q.funct;
  assign alu_add_rshift_type = iss_ctrl_q.add_rshift_type;
  assign alu_a               = iss_a_q;
  assign alu_b               = iss_b_q;

  // Response registers load only when their owner retires from the issue stage.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    logic [WIDTH-1:0] data_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        tag_q  <= '0;
      end else if (iss_vld_q && (iss_ctrl_q.owner == 1'(i))) begin
        data_q <= alu_result;
        tag_q  <= iss_tag_q;
      end
    end

    assign rsp_data[i*WIDTH +: WIDTH] = data_q;
    assign rsp_tag[i*TAG_W +: TAG_W]  = tag_q;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural ALUdec+ALU on the shared port.
`timescale 1ns/1ps
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_opcode;
  logic [5:0]  req_funct;
  logic [1:0]  req_add_rshift_type;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_tag;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct;
  logic        alu_add_rshift_type;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic [7:0]  rsp_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_opcode          (req_opcode),
    .req_funct           (req_funct),
    .req_add_rshift_type (req_add_rshift_type),
    .req_a               (req_a),
    .req_b               (req_b),
    .req_tag             (req_tag),
    .alu_opcode          (alu_opcode),
    .alu_funct           (alu_funct),
    .alu_add_rshift_type (alu_add_rshift_type),
    .alu_a               (alu_a),
    .alu_b               (alu_b),
    .alu_result          (alu_result),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_tag             (rsp_tag)
  );

  // Stand-in for the shared decoder+ALU; unknown opcodes return a marker pattern.
  function automatic logic [31:0] alu_model(input logic [6:0] opc, input logic [2:0] f,
                                            input logic rs, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    if (opc == OPC_LUI) begin
      r = b;
    end else if (opc == OPC_RTYPE || opc == OPC_ITYPE) begin
      case (f)
        3'b000: if (opc == OPC_RTYPE && rs) r = a - b; else r = a + b;
        3'b001: r = a << b[4:0];
        3'b010: r = {31'd0, $signed(a) < $signed(b)};
        3'b011: r = {31'd0, a < b};
        3'b100: r = a ^ b;
        3'b101: if (rs) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
        3'b110: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  assign alu_result = alu_model(alu_opcode, alu_funct, alu_add_rshift_type, alu_a, alu_b);

  task automatic set_req(input int i, input logic [6:0] opc, input logic [2:0] f, input logic rs,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    req_opcode[i*7 +: 7]   = opc;
    req_funct[i*3 +: 3]    = f;
    req_add_rshift_type[i] = rs;
    req_a[i*32 +: 32]      = a;
    req_b[i*32 +: 32]      = b;
    req_tag[i*4 +: 4]      = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req_opcode = '0; req_funct = '0; req_add_rshift_type = '0;
    req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_cmp++; if (rsp_data !== 64'd0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (rsp_tag !== 8'd0) begin n_bad++; $display("FAIL reset_rsp_tag: got %h want 0", rsp_tag); end
    n_cmp++; if ({alu_opcode, alu_funct, alu_add_rshift_type, alu_a, alu_b} !== 75'd0) begin
      n_bad++; $display("FAIL reset_alu_out: got op %h a %h b %h want all 0", alu_opcode, alu_a, alu_b);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL ready_before_edge: got %b want 00", req_ready); end
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b11) begin n_bad++; $display("FAIL ready_after_edge: got %b want 11", req_ready); end
  endtask

  task automatic test_add_pipe();
    set_req(0, OPC_RTYPE, 3'b000, 1'b0, 32'd5, 32'd3, 4'd2);
    req_valid = 2'b01;
    #1;
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", req_ready[0]); end
    @(negedge clk);
    req_valid = 2'b00;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL add_issue_rsp: got %b want 00", rsp_valid); end
    n_cmp++; if ({alu_opcode, alu_a, alu_b} !== {OPC_RTYPE, 32'd5, 32'd3}) begin
      n_bad++; $display("FAIL add_alu_drive: got op %b a %0d b %0d want 0110011 5 3", alu_opcode, alu_a, alu_b);
    end
    n_cmp++; if (req_ready[0] !== 1'b0) begin n_bad++; $display("FAIL add_busy_ready: got %b want 0", req_ready[0]); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_data[31:0] !== 32'd8) begin n_bad++; $display("FAIL add_rsp_data: got %0d want 8", rsp_data[31:0]); end
    n_cmp++; if (rsp_tag[3:0] !== 4'd2) begin n_bad++; $display("FAIL add_rsp_tag: got %0d want 2", rsp_tag[3:0]); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    n_cmp++; if ({rsp_valid, req_ready} !== 4'b0011) begin
      n_bad++; $display("FAIL add_release: got valid %b ready %b want 00 11", rsp_valid, req_ready);
    end
  endtask

  task automatic test_sub_aux();
    set_req(1, OPC_RTYPE, 3'b000, 1'b1, 32'd5, 32'd3, 4'd7);
    req_valid = 2'b10;
    rsp_ready = 2'b10;  // early ready must be ignored while no response is pending
    @(negedge clk);
    req_valid = 2'b00;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL sub_issue_rsp: got %b want 00", rsp_valid); end
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL sub_busy_ready: got %b want 01", req_ready); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL sub_rsp_valid: got %b want 10", rsp_valid); end
    n_cmp++; if (rsp_data[63:32] !== 32'd2) begin n_bad++; $display("FAIL sub_rsp_data: got %0d want 2", rsp_data[63:32]); end
    n_cmp++; if (rsp_tag[7:4] !== 4'd7) begin n_bad++; $display("FAIL sub_rsp_tag: got %0d want 7", rsp_tag[7:4]); end
    @(negedge clk);
    rsp_ready = 2'b00;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL sub_release: got %b want 00", rsp_valid); end
  endtask

  task automatic test_contest();
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int w;
      int l;
      logic [31:0] a_w;
      logic [31:0] a_l;
`ifdef ALU_ARB_FIXED_PRI_EN
      w = 0;
`else
      w = k % 2;
`endif
      l = 1 - w;
      a_w = (w == 0) ? 32'(100 + k) : 32'(200 + k);
      a_l = (l == 0) ? 32'(100 + k) : 32'(200 + k);
      set_req(0, OPC_ITYPE, 3'b000, 1'b0, 32'(100 + k), 32'd1, 4'(k));
      set_req(1, OPC_ITYPE, 3'b000, 1'b0, 32'(200 + k), 32'd1, 4'(8 + k));
      req_valid = 2'b11;
      #1;
      n_cmp++; if (req_ready !== 2'(1 << w)) begin
        n_bad++; $display("FAIL contest%0d_ready: got %b want winner %0d only", k, req_ready, w);
      end
      @(negedge clk);
      n_cmp++; if (alu_a !== a_w) begin n_bad++; $display("FAIL contest%0d_winner: got a %0d want %0d", k, alu_a, a_w); end
      req_valid[w] = 1'b0;
      @(negedge clk);
      req_valid = 2'b00;
      n_cmp++; if (alu_a !== a_l) begin n_bad++; $display("FAIL contest%0d_loser_issue: got a %0d want %0d", k, alu_a, a_l); end
      n_cmp++; if (rsp_valid !== 2'(1 << w) || rsp_data[w*32 +: 32] !== a_w + 32'd1) begin
        n_bad++; $display("FAIL contest%0d_winner_rsp: got valid %b data %0d want %b %0d", k, rsp_valid, rsp_data[w*32 +: 32], 2'(1 << w), a_w + 32'd1);
      end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'(1 << l) || rsp_data[l*32 +: 32] !== a_l + 32'd1) begin
        n_bad++; $display("FAIL contest%0d_loser_rsp: got valid %b data %0d want %b %0d", k, rsp_valid, rsp_data[l*32 +: 32], 2'(1 << l), a_l + 32'd1);
      end
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b11) begin n_bad++; $display("FAIL contest%0d_idle: got %b want 11", k, req_ready); end
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_sra_hold();
    set_req(0, OPC_ITYPE, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 4'd3);
    req_valid = 2'b01;
    rsp_ready = 2'b10;
    @(negedge clk);
    set_req(1, OPC_RTYPE, 3'b000, 1'b0, 32'd7, 32'd9, 4'd5);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if ({rsp_valid[0], rsp_data[31:0], rsp_tag[3:0]} !== {1'b1, 32'hF800_0000, 4'd3}) begin
        n_bad++; $display("FAIL sra_hold%0d: got valid %b data %h tag %0d want 1 f8000000 3", c, rsp_valid[0], rsp_data[31:0], rsp_tag[3:0]);
      end
      n_cmp++; if (req_ready[0] !== 1'b0) begin n_bad++; $display("FAIL sra_ready%0d: got %b want 0", c, req_ready[0]); end
      if (c == 0) begin
        n_cmp++; if (alu_a !== 32'd7) begin n_bad++; $display("FAIL sra_aux_issue: got a %0d want 7", alu_a); end
      end
      if (c == 1) begin
        n_cmp++; if ({rsp_valid[1], rsp_data[63:32], rsp_tag[7:4]} !== {1'b1, 32'd16, 4'd5}) begin
          n_bad++; $display("FAIL sra_aux_rsp: got valid %b data %0d tag %0d want 1 16 5", rsp_valid[1], rsp_data[63:32], rsp_tag[7:4]);
        end
      end
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL sra_release: got %b want 00", rsp_valid); end
  endtask

  task automatic test_reset_mid();
    set_req(1, OPC_RTYPE, 3'b000, 1'b0, 32'd11, 32'd22, 4'hA);
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b00;
    n_cmp++; if (alu_a !== 32'd11) begin n_bad++; $display("FAIL rstmid_in_issue: got a %0d want 11", alu_a); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({req_ready, rsp_valid} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_during: got ready %b valid %b want 00 00", req_ready, rsp_valid);
    end
    n_cmp++; if (alu_a !== 32'd0) begin n_bad++; $display("FAIL rstmid_issue_flush: got a %0d want 0", alu_a); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rstmid_no_rsp%0d: got %b want 00", c, rsp_valid); end
    end
    n_cmp++; if ({req_ready, rsp_tag[7:4]} !== {2'b11, 4'd0}) begin
      n_bad++; $display("FAIL rstmid_after: got ready %b tag %h want 11 0", req_ready, rsp_tag[7:4]);
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_lui();
    int waited;
    set_req(0, OPC_LUI, 3'b000, 1'b0, 32'h0000_FFFF, 32'h1234_5000, 4'd6);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    waited = 1;
    while (!rsp_valid[0] && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (waited !== 2) begin n_bad++; $display("FAIL lui_latency: got %0d edges want 2", waited); end
    n_cmp++; if ({rsp_valid[0], rsp_data[31:0]} !== {1'b1, 32'h1234_5000}) begin
      n_bad++; $display("FAIL lui_data: got valid %b data %h want 1 12345000", rsp_valid[0], rsp_data[31:0]);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_unsupported();
    set_req(1, 7'b1111111, 3'b010, 1'b0, 32'd1, 32'd2, 4'd1);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_cmp++; if ({rsp_valid[1], rsp_data[63:32], rsp_tag[7:4]} !== {1'b1, 32'hDEAD_BEEF, 4'd1}) begin
      n_bad++; $display("FAIL unsup_rsp: got valid %b data %h tag %0d want 1 deadbeef 1", rsp_valid[1], rsp_data[63:32], rsp_tag[7:4]);
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL unsup_release: got %b want 00", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_add_pipe();
    test_sub_aux();
    test_contest();
    test_sra_hold();
    test_reset_mid();
    test_lui();
    test_unsupported();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
